// File: rtl/vga_tile_fb.sv
// Tile frame buffer: a register port queues rectangle/pixel fills, a fill engine
// writes one tile per cycle, and the scan port streams tile colours to video.
module vga_tile_fb #(
  parameter int unsigned CD        = 12,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned FifoDepth = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 device_req_i,
  input  logic [AddrWidth-1:0] device_addr_i,
  input  logic                 device_we_i,
  input  logic [3:0]           device_be_i,
  input  logic [DataWidth-1:0] device_wdata_i,
  output logic                 device_rvalid_o,
  output logic [DataWidth-1:0] device_rdata_o,
  input  logic [10:0]          hcount,
  input  logic [10:0]          vcount,
  input  logic                 video_on,
  output logic [CD-1:0]        vga_si_rgb
);

  localparam int unsigned TilesX = 80;
  localparam int unsigned TilesY = 60;
  localparam int unsigned Tiles  = TilesX * TilesY;
  localparam int unsigned RamAw  = $clog2(Tiles);
  localparam int unsigned EntryW = CD + 26;
  localparam int unsigned PtrW   = $clog2(FifoDepth);
  localparam int unsigned CntW   = PtrW + 1;
  localparam logic [6:0]  XMax   = 7'(TilesX - 1);
  localparam logic [5:0]  YMax   = 6'(TilesY - 1);

  typedef enum logic [1:0] {IDLE, LOAD, FILL} state_t;

  state_t state, state_d;

  logic [CD-1:0]     ram [Tiles];
  logic [EntryW-1:0] fifo_mem [FifoDepth];
  logic [PtrW-1:0]   wr_ptr, rd_ptr;
  logic [CntW-1:0]   count;
  logic              full, empty, push, push_ok, pop;
  logic [EntryW-1:0] push_data;

  logic [CD-1:0]     fill_color;
  logic              overflow, busy;
  logic [1:0]        reg_sel;
  logic              acc_wr;
  logic [DataWidth-1:0] status, rd_word;

  logic [CD-1:0]     h_col;
  logic [6:0]        h_x0, h_x1;
  logic [5:0]        h_y0, h_y1;
  logic [CD-1:0]     cmd_col;
  logic [6:0]        cmd_x0, cmd_x1, cx;
  logic [5:0]        cmd_y0, cmd_y1, cy;
  logic              cmd_ok, fill_we, at_x1, at_last;
  logic [RamAw-1:0]  wr_addr, rd_addr;
  logic              rd_ok, von1;
  logic [6:0]        tx, ty;
  logic              unused_bits;

  assign unused_bits = ^{device_be_i, device_addr_i, device_wdata_i, hcount, vcount};

  assign reg_sel = device_addr_i[3:2];
  assign acc_wr  = device_req_i & device_we_i;

  // RECT captures FILL_COLOR at push time; PIXEL carries its own colour
  always_comb begin
    push      = 1'b0;
    push_data = '0;
    if (acc_wr && reg_sel == 2'd1) begin
      push      = 1'b1;
      push_data = {fill_color, device_wdata_i[6:0], device_wdata_i[13:8],
                   device_wdata_i[22:16], device_wdata_i[29:24]};
    end else if (acc_wr && reg_sel == 2'd3) begin
      push      = 1'b1;
      push_data = {device_wdata_i[16 +: CD], device_wdata_i[6:0], device_wdata_i[13:8],
                   device_wdata_i[6:0], device_wdata_i[13:8]};
    end
  end

  assign full    = (count == CntW'(FifoDepth));
  assign empty   = (count == '0);
  assign push_ok = push & (~full | pop);
  assign busy    = (state != IDLE) | ~empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PtrW'(1);
      if (pop)     rd_ptr <= rd_ptr + PtrW'(1);
      count <= count + CntW'(push_ok) - CntW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= push_data;
  end

  always_comb begin
    status = DataWidth'({3'(count), full, overflow, busy});
    case (reg_sel)
      2'd0:    rd_word = DataWidth'(fill_color);
      2'd2:    rd_word = status;
      default: rd_word = '0;
    endcase
  end

  // Register file and one-cycle bus response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill_color      <= '0;
      overflow        <= 1'b0;
      device_rvalid_o <= 1'b0;
      device_rdata_o  <= '0;
    end else begin
      device_rvalid_o <= device_req_i;
      device_rdata_o  <= (device_req_i && !device_we_i) ? rd_word : '0;
      if (acc_wr && reg_sel == 2'd0) fill_color <= device_wdata_i[CD-1:0];
      if (push && !push_ok) begin
        overflow <= 1'b1;
      end else if (acc_wr && reg_sel == 2'd2 && device_wdata_i[1]) begin
        overflow <= 1'b0;
      end
    end
  end

  assign {h_col, h_x0, h_y0, h_x1, h_y1} = fifo_mem[rd_ptr];

  assign cmd_ok  = (cmd_x1 >= cmd_x0) && (cmd_y1 >= cmd_y0);
  assign at_x1   = (cx == cmd_x1);
  assign at_last = at_x1 && (cy == cmd_y1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    pop     = 1'b0;
    fill_we = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: state_d = cmd_ok ? FILL : IDLE;
      FILL: begin
        fill_we = 1'b1;
        if (at_last) begin
          if (empty) begin
            state_d = IDLE;
          end else begin
            pop     = 1'b1;
            state_d = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Command is clipped as it leaves the FIFO so LOAD only needs the order check
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_col <= '0;
      cmd_x0  <= '0;
      cmd_y0  <= '0;
      cmd_x1  <= '0;
      cmd_y1  <= '0;
      cx      <= '0;
      cy      <= '0;
    end else begin
      if (pop) begin
        cmd_col <= h_col;
        cmd_x0  <= (h_x0 > XMax) ? XMax : h_x0;
        cmd_y0  <= (h_y0 > YMax) ? YMax : h_y0;
        cmd_x1  <= (h_x1 > XMax) ? XMax : h_x1;
        cmd_y1  <= (h_y1 > YMax) ? YMax : h_y1;
      end
      if (state == LOAD) begin
        cx <= cmd_x0;
        cy <= cmd_y0;
      end else if (fill_we) begin
        if (at_x1) begin
          cx <= cmd_x0;
          cy <= cy + 6'd1;
        end else begin
          cx <= cx + 7'd1;
        end
      end
    end
  end

  assign wr_addr = RamAw'(cy) * RamAw'(TilesX) + RamAw'(cx);

  always_ff @(posedge clk) begin
    if (fill_we) ram[wr_addr] <= cmd_col;
  end

  assign tx = hcount[9:3];
  assign ty = vcount[9:3];

  // Two-stage scan: address register, then RAM data gated by delayed video_on
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_addr    <= '0;
      rd_ok      <= 1'b0;
      von1       <= 1'b0;
      vga_si_rgb <= '0;
    end else begin
      rd_addr    <= RamAw'(ty) * RamAw'(TilesX) + RamAw'(tx);
      rd_ok      <= (tx < 7'(TilesX)) && (ty < 7'(TilesY));
      von1       <= video_on;
      vga_si_rgb <= (von1 && rd_ok) ? ram[rd_addr] : '0;
    end
  end

endmodule

// File: doc/vga_tile_fb.md
VGA_TILE_FB -- requirements
Module: vga_tile_fb

Interface
REQ-001 Parameter CD, default 12: colour depth in bits.
REQ-002 Parameter AddrWidth, default 32: bus address width.
REQ-003 Parameter DataWidth, default 32: bus data width.
REQ-004 Parameter FifoDepth, default 4: command FIFO entries, power of two.
REQ-005 Ports SHALL be:
- clk  in  1  single system clock.
- reset  in  1  asynchronous, active-high reset.
- device_req_i  in  1  bus request.
- device_addr_i  in  AddrWidth  byte address; only bits [3:2] decoded.
- device_we_i  in  1  write enable.
- device_be_i  in  4  byte enables; ignored, all writes are full-word.
- device_wdata_i  in  DataWidth  write data.
- device_rvalid_o  out  1  response valid.
- device_rdata_o  out  DataWidth  read data.
- hcount  in  11  scan x from the frame counter.
- vcount  in  11  scan y from the frame counter.
- video_on  in  1  active-display flag.
- vga_si_rgb  out  CD  pixel colour stream to the sync stage.

Function
REQ-006 Frame buffer SHALL be an 80x60-tile RAM, CD bits per tile, address = ty*80+tx; 8x8 screen pixels per tile.
REQ-007 Register map, word offsets:
- 0x0 FILL_COLOR: R/W, bits [CD-1:0].
- 0x4 RECT: write-only, x0[6:0], y0[13:8], x1[22:16], y1[29:24]; pushes {FILL_COLOR, rect} into the FIFO.
- 0x8 STATUS: R/W. Read: bit0 busy, bit1 overflow (sticky), bit2 fifo_full, bits[5:3] fifo count. Writing 1 to bit1 clears overflow.
- 0xC PIXEL: write-only, x[6:0], y[13:8], colour[27:16]; pushes {colour, x, y, x, y}.
REQ-008 device_rvalid_o SHALL pulse exactly one cycle after every accepted req, read or write.
REQ-009 device_rdata_o SHALL be valid with rvalid; write-only offsets read 0; data SHALL be 0 when the access is a write.
REQ-010 A push while the FIFO is full, with no pop in the same cycle, SHALL be dropped and SHALL set overflow. A push and pop in the same cycle on a full FIFO SHALL both succeed.
REQ-011 Fill FSM states: IDLE, LOAD, FILL.
- IDLE: FIFO not empty -> LOAD (pop).
- LOAD: clip x0/x1 to 79 and y0/y1 to 59. If x1<x0 or y1<y0, discard the command with zero RAM writes -> IDLE. Otherwise set cx=x0, cy=y0 -> FILL.
- FILL: write colour at (cx,cy), one tile per cycle. cx increments to x1, then wraps to x0 while cy increments. After writing (x1,y1): -> IDLE if the FIFO is empty, else -> LOAD.
REQ-012 A rectangle of W×H tiles SHALL take exactly 1+W*H cycles from LOAD entry to return to IDLE/LOAD.
REQ-013 busy SHALL be 1 when the FSM is not IDLE or the FIFO is non-empty.
REQ-014 Scan read: tx=hcount[9:3], ty=vcount[9:3]; read-address register then registered RAM data.
REQ-015 vga_si_rgb SHALL have 2-cycle latency from hcount/vcount/video_on; video_on SHALL be delayed 2 cycles to match; output SHALL be 0 when delayed video_on=0.
REQ-016 Scan reads and fill writes SHALL proceed concurrently. A read of the address written in the same cycle SHALL return the old data.
REQ-017 FILL_COLOR changes after a RECT push SHALL NOT affect that queued command.

Reset
REQ-018 On reset assertion, with no clock required: FSM IDLE, FIFO empty, overflow 0, FILL_COLOR 0, device_rvalid_o 0, device_rdata_o 0, vga_si_rgb 0, video_on delay line 0.
REQ-019 RAM contents SHALL NOT be reset.
REQ-020 Reset during FILL SHALL abandon the command; RAM writes already made SHALL remain.

Verification
REQ-021 Write FILL_COLOR=0xF00, RECT (0,0,79,59) -> busy for 4801 cycles; scan at hcount=100, vcount=200, video_on=1 -> vga_si_rgb=0xF00 two cycles later.
REQ-022 PIXEL x=5, y=3, colour 0x0A5 -> hcount 40..47, vcount 24..31 read 0x0A5; hcount=48 reads the previous value.
REQ-023 Five back-to-back RECT writes while the first is filling -> STATUS overflow=1, fifo_full=1; write STATUS=0x2 -> overflow=0.
REQ-024 RECT x0=10, x1=5 -> zero RAM writes, busy drops after 2 cycles; RECT x1=100, y1=70 -> fills to column 79, row 59.
REQ-025 video_on=0 with any hcount/vcount -> vga_si_rgb=0 two cycles later.
REQ-026 Assert reset mid-FILL of (0,0,79,59) -> outputs 0 immediately; after release, STATUS reads 0 and already-written tiles are unchanged.
